wb_master_arbiter: RTL and testbench

// - Shares the single Wishbone IO master port of wb_intercon among NUM_MASTERS requesters.

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_rr_pick.sv | 31 +++
 rtl/wb_master_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_master_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the Wishbone master arbiter.
package wb_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_BUSY
   } arb_state_e;

   localparam int WB_AW = 32;
   localparam int WB_DW = 32;
   localparam int WB_SW = 4;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after the last winner, wrapping.
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 3
) (
   input  logic [NUM_MASTERS-1:0]         req,
   input  logic [$clog2(NUM_MASTERS)-1:0] last,
   output logic                           valid,
   output logic [$clog2(NUM_MASTERS)-1:0] winner
);

   localparam int IW = $clog2(NUM_MASTERS);

   int unsigned idx;

   // Scan last+1 .. last+NUM_MASTERS modulo NUM_MASTERS and keep the first hit.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         idx = (32'(last) + k) % NUM_MASTERS;
         if (!valid && req[IW'(idx)]) begin
            valid  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among NUM_MASTERS
// requesters, with a per-transfer stall watchdog.
module wb_master_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 3,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_ni,
   input  logic [WB_AW*NUM_MASTERS-1:0]   wbm_adr_i,
   input  logic [WB_DW*NUM_MASTERS-1:0]   wbm_dat_i,
   input  logic [WB_SW*NUM_MASTERS-1:0]   wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]         wbm_we_i,
   input  logic [NUM_MASTERS-1:0]         wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]         wbm_stb_i,
   output logic [WB_DW*NUM_MASTERS-1:0]   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]         wbm_ack_o,
   output logic [NUM_MASTERS-1:0]         wbm_err_o,
   output logic [NUM_MASTERS-1:0]         wbm_rty_o,
   output logic [WB_AW-1:0]               wbs_adr_o,
   output logic [WB_DW-1:0]               wbs_dat_o,
   output logic [WB_SW-1:0]               wbs_sel_o,
   output logic                           wbs_we_o,
   output logic                           wbs_cyc_o,
   output logic                           wbs_stb_o,
   input  logic [WB_DW-1:0]               wbs_dat_i,
   input  logic                           wbs_ack_i,
   input  logic                           wbs_err_i,
   input  logic                           wbs_rty_i,
   output logic                           timeout_o,
   output logic [$clog2(NUM_MASTERS)-1:0] timeout_mst_o
);

   localparam int               IW       = $clog2(NUM_MASTERS);
   localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e       state, state_d;
   logic [IW-1:0]    gnt, gnt_d;
   logic [IW-1:0]    last_grant, last_d;
   logic [IW-1:0]    tmo_mst_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic             cyc_g, stb_g, resp, stalled, fire;

   logic [WB_AW-1:0] adr_m  [NUM_MASTERS];
   logic [WB_DW-1:0] wdat_m [NUM_MASTERS];
   logic [WB_SW-1:0] sel_m  [NUM_MASTERS];
   logic [WB_DW-1:0] rdat_m [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign adr_m[g]                    = wbm_adr_i[g*WB_AW +: WB_AW];
      assign wdat_m[g]                   = wbm_dat_i[g*WB_DW +: WB_DW];
      assign sel_m[g]                    = wbm_sel_i[g*WB_SW +: WB_SW];
      assign wbm_dat_o[g*WB_DW +: WB_DW] = rdat_m[g];
   end

   wb_rr_pick #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_pick (
      .req   (wbm_cyc_i),
      .last  (last_grant),
      .valid (pick_valid),
      .winner(pick_idx)
   );

   // State, grant, round-robin pointer, watchdog counter and last timeout source.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state         <= ARB_IDLE;
         gnt           <= '0;
         last_grant    <= IW'(NUM_MASTERS - 1);
         cnt           <= '0;
         timeout_mst_o <= '0;
      end else begin
         state         <= state_d;
         gnt           <= gnt_d;
         last_grant    <= last_d;
         cnt           <= cnt_d;
         timeout_mst_o <= tmo_mst_d;
      end
   end

   // Next-state, bus muxing, response routing and watchdog decision.
   always_comb begin
      state_d   = state;
      gnt_d     = gnt;
      last_d    = last_grant;
      cnt_d     = '0;
      tmo_mst_d = timeout_mst_o;
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      timeout_o = 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) rdat_m[i] = '0;
      cyc_g   = wbm_cyc_i[gnt];
      stb_g   = wbm_stb_i[gnt];
      resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
      stalled = 1'b0;
      fire    = 1'b0;

      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_idx;
               state_d = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            wbs_adr_o = adr_m[gnt];
            wbs_dat_o = wdat_m[gnt];
            wbs_sel_o = sel_m[gnt];
            wbs_we_o  = wbm_we_i[gnt];
            if (cyc_g) begin
               // A response in the would-be firing cycle takes priority over the watchdog.
               stalled        = WD_EN && stb_g && !resp;
               fire           = stalled && (cnt >= CNT_LAST);
               wbs_cyc_o      = 1'b1;
               wbs_stb_o      = stb_g && !fire;
               rdat_m[gnt]    = wbs_dat_i;
               wbm_ack_o[gnt] = wbs_ack_i;
               wbm_err_o[gnt] = wbs_err_i | fire;
               wbm_rty_o[gnt] = wbs_rty_i;
               timeout_o      = fire;
               if (fire) begin
                  tmo_mst_d = gnt;
               end else if (stalled) begin
                  cnt_d = (cnt == '1) ? cnt : cnt + 1'b1;
               end
            end else begin
               state_d = ARB_IDLE;
               last_d  = gnt;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter (3 masters, 8-cycle watchdog).
module tb_wb_master_arbiter;

   localparam int          N  = 3;
   localparam logic [31:0] A0 = 32'h1000_0000;
   localparam logic [31:0] A1 = 32'h1000_0010;
   localparam logic [31:0] A2 = 32'h1000_0020;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [95:0]   m_adr, m_dat, rd_dat;
   logic [11:0]   m_sel;
   logic [2:0]    m_we, m_cyc, m_stb, ack_o, err_o, rty_o;
   logic [31:0]   s_adr, s_wdat, s_rdat;
   logic [3:0]    s_sel;
   logic          s_we, s_cyc, s_stb, s_ack, s_err, s_rty, tmo;
   logic [1:0]    tmo_mst;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_master_arbiter #(
      .NUM_MASTERS(N),
      .TIMEOUT_CYCLES(8),
      .CNT_W(8)
   ) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
      .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
      .wbm_dat_o(rd_dat), .wbm_ack_o(ack_o), .wbm_err_o(err_o), .wbm_rty_o(rty_o),
      .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
      .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb),
      .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .timeout_o(tmo), .timeout_mst_o(tmo_mst)
   );

   typedef struct {
      logic [2:0]  cyc;
      logic        ack;
      logic        e_cyc;
      logic [31:0] e_adr;
      logic [2:0]  e_ack;
   } vec_t;

   vec_t tbl [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      s_rty = 1'b0;
      nxt();
      nxt();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input logic [2:0] r);
      m_cyc = r;
      m_stb = r;
   endtask

   // Reference model state for the random phase.
   int      owner, last, streak;
   int      beats [N];
   bit      act [N];
   logic [95:0] e_rd;
   logic [2:0]  e_ack, e_err, e_rty;
   bit          e_cyc, e_stb;

   initial begin
      tbl[0]  = '{3'b111, 1'b0, 1'b0, 32'h0, 3'b000};
      tbl[1]  = '{3'b111, 1'b1, 1'b1, A0,    3'b001};
      tbl[2]  = '{3'b110, 1'b0, 1'b0, A0,    3'b000};
      tbl[3]  = '{3'b111, 1'b0, 1'b0, 32'h0, 3'b000};
      tbl[4]  = '{3'b111, 1'b1, 1'b1, A1,    3'b010};
      tbl[5]  = '{3'b101, 1'b0, 1'b0, A1,    3'b000};
      tbl[6]  = '{3'b111, 1'b1, 1'b0, 32'h0, 3'b000};
      tbl[7]  = '{3'b111, 1'b1, 1'b1, A2,    3'b100};
      tbl[8]  = '{3'b011, 1'b0, 1'b0, A2,    3'b000};
      tbl[9]  = '{3'b111, 1'b0, 1'b0, 32'h0, 3'b000};
      tbl[10] = '{3'b111, 1'b0, 1'b1, A0,    3'b000};
      tbl[11] = '{3'b111, 1'b1, 1'b1, A0,    3'b001};
      tbl[12] = '{3'b110, 1'b0, 1'b0, A0,    3'b000};
      tbl[13] = '{3'b111, 1'b0, 1'b0, 32'h0, 3'b000};
      tbl[14] = '{3'b111, 1'b1, 1'b1, A1,    3'b010};
      tbl[15] = '{3'b101, 1'b0, 1'b0, A1,    3'b000};
      tbl[16] = '{3'b111, 1'b0, 1'b0, 32'h0, 3'b000};
      tbl[17] = '{3'b111, 1'b1, 1'b1, A2,    3'b100};
      tbl[18] = '{3'b011, 1'b0, 1'b0, A2,    3'b000};
      tbl[19] = '{3'b000, 1'b1, 1'b0, 32'h0, 3'b000};

      m_adr  = {A2, A1, A0};
      m_dat  = {32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
      m_sel  = 12'hFFF;
      m_we   = 3'b000;
      s_rdat = 32'h0;

      // Reset state: every output zero after the reset edge.
      rst_n = 1'b0;
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      s_err = 1'b0;
      s_rty = 1'b0;
      nxt();
      #3;
      check("rst cyc", 32'(s_cyc), 32'h0);
      check("rst stb", 32'(s_stb), 32'h0);
      check("rst adr", s_adr, 32'h0);
      check("rst wdat", s_wdat, 32'h0);
      check("rst sel", 32'(s_sel), 32'h0);
      check("rst we", 32'(s_we), 32'h0);
      check("rst ack", 32'(ack_o), 32'h0);
      check("rst err", 32'(err_o), 32'h0);
      check("rst rty", 32'(rty_o), 32'h0);
      check("rst rdat0", rd_dat[31:0], 32'h0);
      check("rst tmo", 32'(tmo), 32'h0);
      check("rst tmo_mst", 32'(tmo_mst), 32'h0);
      nxt();
      rst_n = 1'b1;

      // Single master 0 read, slave acks two cycles after stb.
      m_adr[31:0] = 32'h2000_0000;
      set_req(3'b001);
      #3; check("s1 bubble cyc", 32'(s_cyc), 32'h0); nxt();
      #3;
      check("s1 cyc", 32'(s_cyc), 32'h1);
      check("s1 stb", 32'(s_stb), 32'h1);
      check("s1 adr", s_adr, 32'h2000_0000);
      check("s1 we", 32'(s_we), 32'h0);
      check("s1 sel", 32'(s_sel), 32'hF);
      check("s1 wait ack", 32'(ack_o), 32'h0);
      nxt();
      #3; check("s1 wait2 ack", 32'(ack_o), 32'h0); nxt();
      s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
      #3;
      check("s1 ack", 32'(ack_o), 32'h1);
      check("s1 rdat0", rd_dat[31:0], 32'hCAFE_F00D);
      check("s1 rdat1", rd_dat[63:32], 32'h0);
      nxt();
      s_ack = 1'b0; set_req(3'b000);
      #3; check("s1 drop cyc", 32'(s_cyc), 32'h0); nxt();
      m_adr[31:0] = A0;

      // Round-robin among three continuous requesters.
      do_reset();
      for (int v = 0; v < 20; v++) begin
         set_req(tbl[v].cyc);
         s_ack = tbl[v].ack;
         #3;
         check($sformatf("rr%0d cyc", v), 32'(s_cyc), 32'(tbl[v].e_cyc));
         check($sformatf("rr%0d stb", v), 32'(s_stb), 32'(tbl[v].e_cyc));
         check($sformatf("rr%0d adr", v), s_adr, tbl[v].e_adr);
         check($sformatf("rr%0d ack", v), 32'(ack_o), 32'(tbl[v].e_ack));
         nxt();
      end
      s_ack = 1'b0;

      // Master 1 locked for four beats while master 0 waits.
      do_reset();
      set_req(3'b010);
      #3; check("s3 bubble", 32'(s_cyc), 32'h0); nxt();
      for (int b = 0; b < 4; b++) begin
         set_req(3'b011); s_ack = 1'b1;
         #3;
         check($sformatf("s3 beat%0d ack", b), 32'(ack_o), 32'h2);
         check($sformatf("s3 beat%0d adr", b), s_adr, A1);
         nxt();
      end
      set_req(3'b001); s_ack = 1'b0;
      #3; check("s3 drop cyc", 32'(s_cyc), 32'h0); nxt();
      #3; check("s3 idle cyc", 32'(s_cyc), 32'h0); nxt();
      #3;
      check("s3 m0 cyc", 32'(s_cyc), 32'h1);
      check("s3 m0 adr", s_adr, A0);
      nxt();
      set_req(3'b000); nxt(); nxt();

      // Watchdog: master 2 stalled, fires on the 8th stalled cycle.
      do_reset();
      set_req(3'b100);
      #3; check("wd bubble", 32'(s_cyc), 32'h0); nxt();
      for (int c = 1; c <= 8; c++) begin
         #3;
         if (c < 8) begin
            check($sformatf("wd c%0d err", c), 32'(err_o), 32'h0);
            check($sformatf("wd c%0d tmo", c), 32'(tmo), 32'h0);
            check($sformatf("wd c%0d stb", c), 32'(s_stb), 32'h1);
         end else begin
            check("wd fire err", 32'(err_o), 32'h4);
            check("wd fire tmo", 32'(tmo), 32'h1);
            check("wd fire stb", 32'(s_stb), 32'h0);
            check("wd fire cyc", 32'(s_cyc), 32'h1);
         end
         nxt();
      end
      #3;
      check("wd after tmo", 32'(tmo), 32'h0);
      check("wd after err", 32'(err_o), 32'h0);
      check("wd tmo_mst", 32'(tmo_mst), 32'h2);
      set_req(3'b000);
      nxt();
      // Same run: ack lands exactly on the 8th stalled cycle.
      set_req(3'b100);
      nxt();
      for (int c = 1; c <= 8; c++) begin
         s_ack = (c == 8);
         #3;
         if (c == 8) begin
            check("wd ack8 ack", 32'(ack_o), 32'h4);
            check("wd ack8 err", 32'(err_o), 32'h0);
            check("wd ack8 tmo", 32'(tmo), 32'h0);
         end
         nxt();
      end
      s_ack = 1'b0;
      set_req(3'b000);
      #3; check("wd tmo_mst held", 32'(tmo_mst), 32'h2); nxt();

      // Reset while master 2 is mid-transfer.
      set_req(3'b100);
      nxt();
      #3; check("mr busy cyc", 32'(s_cyc), 32'h1);
      rst_n = 1'b0; s_ack = 1'b1;
      nxt();
      rst_n = 1'b1; set_req(3'b011);
      #3;
      check("mr cyc", 32'(s_cyc), 32'h0);
      check("mr stb", 32'(s_stb), 32'h0);
      check("mr adr", s_adr, 32'h0);
      check("mr ack", 32'(ack_o), 32'h0);
      check("mr err", 32'(err_o), 32'h0);
      check("mr tmo", 32'(tmo), 32'h0);
      check("mr tmo_mst", 32'(tmo_mst), 32'h0);
      nxt();
      s_ack = 1'b0;
      #3;
      check("mr first cyc", 32'(s_cyc), 32'h1);
      check("mr first adr", s_adr, A0);
      set_req(3'b000);
      nxt(); nxt();

      // Master 0 abandons before the ack; the late ack is dropped.
      set_req(3'b001); nxt();
      #3; check("ab busy cyc", 32'(s_cyc), 32'h1); nxt();
      set_req(3'b000);
      #3; check("ab drop cyc", 32'(s_cyc), 32'h0); nxt();
      s_ack = 1'b1;
      #3; check("ab late ack", 32'(ack_o), 32'h0); nxt();
      s_ack = 1'b0; set_req(3'b010);
      #3; check("ab next bubble", 32'(s_cyc), 32'h0); nxt();
      s_ack = 1'b1;
      #3;
      check("ab next ack", 32'(ack_o), 32'h2);
      check("ab next adr", s_adr, A1);
      nxt();
      s_ack = 1'b0; set_req(3'b000); nxt(); nxt();

      // Randomized traffic against a grant-ownership model.
      do_reset();
      owner = -1; last = N - 1; streak = 0;
      for (int i = 0; i < N; i++) begin act[i] = 0; beats[i] = 0; end
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++) begin
            if (act[i] && beats[i] == 0) begin
               act[i] = 0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
            end else if (!act[i] && $urandom_range(0, 3) == 0) begin
               act[i] = 1; beats[i] = $urandom_range(1, 3);
               m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
               m_adr[i*32 +: 32] = $urandom;
               m_dat[i*32 +: 32] = $urandom;
            end
         end
         if (streak >= 3) begin
            s_ack = 1'b1; s_err = 1'b0; s_rty = 1'b0;
         end else begin
            int r;
            r = $urandom_range(0, 7);
            s_ack = (r < 3); s_err = (r == 3); s_rty = (r == 4);
         end
         streak = (s_ack | s_err | s_rty) ? 0 : streak + 1;
         s_rdat = $urandom;
         #3;
         e_cyc = (owner >= 0) && m_cyc[owner];
         e_stb = e_cyc && m_stb[owner];
         e_rd = '0; e_ack = '0; e_err = '0; e_rty = '0;
         if (e_cyc) begin
            e_rd[owner*32 +: 32] = s_rdat;
            e_ack[owner] = s_ack; e_err[owner] = s_err; e_rty[owner] = s_rty;
            check("rnd adr", s_adr, m_adr[owner*32 +: 32]);
            check("rnd wdat", s_wdat, m_dat[owner*32 +: 32]);
         end
         check("rnd cyc", 32'(s_cyc), 32'(e_cyc));
         check("rnd stb", 32'(s_stb), 32'(e_stb));
         check("rnd ack", 32'(ack_o), 32'(e_ack));
         check("rnd err", 32'(err_o), 32'(e_err));
         check("rnd rty", 32'(rty_o), 32'(e_rty));
         check("rnd tmo", 32'(tmo), 32'h0);
         for (int i = 0; i < N; i++)
            check($sformatf("rnd rdat%0d", i), rd_dat[i*32 +: 32], e_rd[i*32 +: 32]);
         for (int i = 0; i < N; i++)
            if (act[i] && (ack_o[i] | err_o[i] | rty_o[i]) && beats[i] > 0) beats[i]--;
         if (owner < 0) begin
            for (int j = 1; j <= N; j++)
               if (owner < 0 && m_cyc[(last + j) % N]) owner = (last + j) % N;
         end else if (!m_cyc[owner]) begin
            last = owner;
            owner = -1;
         end
         nxt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
